imm_ext_pipe: RTL and testbench
===============================

// Module: imm_ext_pipe
// PURPOSE
//  Parametrised, registered immediate extender for the PCPU decode->execute boundary.
//  Widens an IMM_W-bit instruction immediate to DATA_W bits in one of five modes.
//  Carries an opaque TAG (PC/rd) alongside, with a valid/ready handshake and a
//  2-entry skid buffer. Adds LUI and branch-offset modes, backpressure, flush and an illegal-op flag.
// PARAMETERS
//  IMM_W    16  immediate input width (IMM_W < DATA_W)
//  DATA_W   32  extended output width
//  BR_SHIFT  2  left shift applied in BRANCH mode (BR_SHIFT <= DATA_W-IMM_W)
//  TAG_W     8  width of the pass-through tag
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  flush      in   1       drop every buffered entry (pipeline squash)
//  in_valid   in   1       input beat valid
//  in_ready   out  1       unit can accept a beat this cycle
//  in_imm     in   IMM_W   raw immediate
//  in_op      in   3       0 ZERO, 1 SIGNED, 2 LUI, 3 BRANCH, 4 INST, 5-7 illegal
//  in_tag     in   TAG_W   pass-through tag
//  out_valid  out  1       output beat valid
//  out_ready  in   1       consumer accepts output beat
//  out_imm    out  DATA_W  extended immediate
//  out_tag    out  TAG_W   tag of the beat on out_imm
//  out_err    out  1       beat was produced from an illegal in_op
// BEHAVIOUR
//  Extension (computed on input side, registered):
//   ZERO   {0, imm}                     SIGNED {{DATA_W-IMM_W}{imm[IMM_W-1]}, imm}
//   LUI    imm << (DATA_W-IMM_W)      BRANCH sign-extend then << BR_SHIFT (MSBs drop)
//   INST   all zeros, err=0           5-7    all zeros, err=1
//  Storage: main register M (drives out_*), skid register S. out_* are always M.
//  State machine (state = {S.v, M.v}):
//   EMPTY: in_ready=1. in_valid -> load M, go ONE.
//   ONE:   in_ready=1. accept & out_ready -> M<=new, stay ONE; accept & !out_ready
//          -> S<=new, go FULL; !accept & out_ready -> go EMPTY; else hold.
//   FULL:  in_ready=0. out_ready -> M<=S, go ONE; else hold.
//  Accept = in_valid & in_ready. Handshake = out_valid & out_ready.
//  in_ready is a function of state only (no comb path from out_ready); 0 during rst.
//  Latency: one cycle from accept to out_valid when empty; throughput 1 beat/cycle.
//  Ordering strictly FIFO; no beat duplicated or lost except by flush/rst.
//  out_imm/out_tag/out_err hold steady while out_valid & !out_ready.
//  flush: next state EMPTY; a beat presented in the flush cycle is dropped
//   (in_ready may read 1, beat still discarded); flush beats any other event.
//  rst: out_valid=0, out_imm=0, out_tag=0, out_err=0, state EMPTY, in_ready=0
//   while rst is high, 1 on the first cycle after; reset mid-transfer discards all.
//  out_imm/out_tag/out_err retain last value after draining (only out_valid drops).
// TESTING
//  1 Defaults, out_ready=1: imm=16'h8001 op SIGNED -> next cycle out_imm=32'hFFFF8001,
//    out_valid=1; op ZERO -> 32'h00008001; op LUI -> 32'h80010000; op BRANCH -> 32'hFFFE0004.
//  2 op=4 imm=16'hFFFF -> out_imm=0, out_err=0; op=6 -> out_imm=0, out_err=1.
//  3 Backpressure: out_ready=0, push tags 1,2 -> in_ready=0 after 2nd; raise out_ready
//    -> outputs tag 1 then tag 2 on consecutive cycles, in_ready back to 1 after first pop.
//  4 Streaming: 100 random beats, random out_ready 50% -> scoreboard exact order/values,
//    out_* stable under stall, no loss.
//  5 Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1; no old beats emerge.
//  6 rst asserted in FULL -> next cycle out_valid=0, out_imm=0, out_tag=0; in_ready=0
//    during rst, 1 the cycle after release.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender for the decode->execute boundary: five widening
// modes, pass-through tag, valid/ready handshake with a two-entry skid buffer.
module imm_ext_pipe #(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [2:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);
    localparam int PAD_W = DATA_W - IMM_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [DATA_W-1:0]  m_imm_reg, s_imm_reg;
    logic [TAG_W-1:0]   m_tag_reg, s_tag_reg;
    logic               m_err_reg, s_err_reg;

    logic [DATA_W-1:0]  sext_imm;
    logic [DATA_W-1:0]  ext_imm_next;
    logic               ext_err_next;
    logic               accept;
    logic               pop;

    assign sext_imm = {{PAD_W{in_imm[IMM_W-1]}}, in_imm};

    // Extension happens before the register so the output side is a plain flop.
    always_comb begin
        ext_imm_next = '0;
        ext_err_next = 1'b0;
        case (in_op)
            3'd0:    ext_imm_next = {{PAD_W{1'b0}}, in_imm};
            3'd1:    ext_imm_next = sext_imm;
            3'd2:    ext_imm_next = {in_imm, {PAD_W{1'b0}}};
            3'd3:    ext_imm_next = sext_imm << BR_SHIFT;
            3'd4:    ext_imm_next = '0;
            default: ext_err_next = 1'b1;
        endcase
    end

    // Ready depends only on occupancy, never on out_ready.
    assign in_ready  = !rst && (state_reg != FULL);
    assign out_valid = (state_reg != EMPTY);
    assign out_imm   = m_imm_reg;
    assign out_tag   = m_tag_reg;
    assign out_err   = m_err_reg;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            m_imm_reg <= '0;
            m_tag_reg <= '0;
            m_err_reg <= 1'b0;
            s_imm_reg <= '0;
            s_tag_reg <= '0;
            s_err_reg <= 1'b0;
        end else if (flush) begin
            // Payload registers keep their contents; only occupancy is dropped.
            state_reg <= EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        m_imm_reg <= ext_imm_next;
                        m_tag_reg <= in_tag;
                        m_err_reg <= ext_err_next;
                        state_reg <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        m_imm_reg <= ext_imm_next;
                        m_tag_reg <= in_tag;
                        m_err_reg <= ext_err_next;
                    end else if (accept) begin
                        s_imm_reg <= ext_imm_next;
                        s_tag_reg <= in_tag;
                        s_err_reg <= ext_err_next;
                        state_reg <= FULL;
                    end else if (pop) begin
                        state_reg <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        m_imm_reg <= s_imm_reg;
                        m_tag_reg <= s_tag_reg;
                        m_err_reg <= s_err_reg;
                        state_reg <= ONE;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed vector table plus hand-written backpressure/flush/reset sequences and
// a randomly stalled streaming run checked against a scoreboard queue.
module tb_imm_ext_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_op;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [7:0]  out_tag;
    logic        out_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_ext_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    typedef struct {
        logic [2:0]  op;
        logic [15:0] imm;
        logic [7:0]  tag;
        logic [31:0] exp_imm;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] imm;
        logic        err;
        logic [7:0]  tag;
    } beat_t;

    vec_t  vecs[14];
    beat_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] tag, input logic [2:0] op, input logic [15:0] imm);
        in_valid = 1'b1;
        in_tag   = tag;
        in_op    = op;
        in_imm   = imm;
        tick();
        in_valid = 1'b0;
    endtask

    // Reference extension written arithmetically (BR_SHIFT=2 -> multiply by 4).
    function automatic logic [32:0] model(input logic [2:0] op, input logic [15:0] imm);
        logic [31:0] s;
        s = {{16{imm[15]}}, imm};
        case (op)
            3'd0:    return {1'b0, 32'(imm)};
            3'd1:    return {1'b0, s};
            3'd2:    return {1'b0, 32'(imm) * 32'd65536};
            3'd3:    return {1'b0, s * 32'd4};
            3'd4:    return {1'b0, 32'd0};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    initial begin
        beat_t held;
        beat_t exp_beat;
        logic [32:0] m;
        bit stall;
        int sent;
        int got;
        int cyc;

        vecs[0]  = '{3'd1, 16'h8001, 8'h10, 32'hFFFF8001, 1'b0};
        vecs[1]  = '{3'd0, 16'h8001, 8'h11, 32'h00008001, 1'b0};
        vecs[2]  = '{3'd2, 16'h8001, 8'h12, 32'h80010000, 1'b0};
        vecs[3]  = '{3'd3, 16'h8001, 8'h13, 32'hFFFE0004, 1'b0};
        vecs[4]  = '{3'd4, 16'hFFFF, 8'h14, 32'h00000000, 1'b0};
        vecs[5]  = '{3'd6, 16'hFFFF, 8'h15, 32'h00000000, 1'b1};
        vecs[6]  = '{3'd5, 16'h1234, 8'h16, 32'h00000000, 1'b1};
        vecs[7]  = '{3'd7, 16'h1234, 8'h17, 32'h00000000, 1'b1};
        vecs[8]  = '{3'd1, 16'h7FFF, 8'h18, 32'h00007FFF, 1'b0};
        vecs[9]  = '{3'd3, 16'h7FFF, 8'h19, 32'h0001FFFC, 1'b0};
        vecs[10] = '{3'd2, 16'h0001, 8'h1A, 32'h00010000, 1'b0};
        vecs[11] = '{3'd0, 16'hFFFF, 8'h1B, 32'h0000FFFF, 1'b0};
        vecs[12] = '{3'd4, 16'h0000, 8'h1C, 32'h00000000, 1'b0};
        vecs[13] = '{3'd3, 16'hFFFF, 8'h1D, 32'hFFFFFFFC, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_op = '0;
        in_tag = '0; out_ready = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_imm", 64'(out_imm), 64'd0);
        check("rst_out_tag_err", 64'({out_tag, out_err}), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Table-driven extension vectors, streamed back-to-back with out_ready=1
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_op    = vecs[i].op;
            in_imm   = vecs[i].imm;
            in_tag   = vecs[i].tag;
            tick();
            check($sformatf("vec%0d", i),
                  64'({out_valid, out_err, out_tag, out_imm}),
                  64'({1'b1, vecs[i].exp_err, vecs[i].tag, vecs[i].exp_imm}));
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid_low", 64'(out_valid), 64'd0);
        check("drain_retain", 64'({out_tag, out_imm}), 64'({8'h1D, 32'hFFFFFFFC}));

        // Backpressure: two beats fill main + skid, then drain in order
        out_ready = 1'b0;
        push(8'd1, 3'd0, 16'h0001);
        check("bp_first_ready", 64'({in_ready, out_valid, out_tag}), 64'({1'b1, 1'b1, 8'd1}));
        push(8'd2, 3'd0, 16'h0002);
        check("bp_full_ready", 64'({in_ready, out_tag, out_imm}), 64'({1'b0, 8'd1, 32'd1}));
        out_ready = 1'b1;
        tick();
        check("bp_pop2", 64'({in_ready, out_valid, out_tag, out_imm}),
              64'({1'b1, 1'b1, 8'd2, 32'd2}));
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Flush in FULL with a beat offered in the same cycle
        out_ready = 1'b0;
        push(8'd3, 3'd1, 16'h0003);
        push(8'd4, 3'd1, 16'h0004);
        check("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        in_valid = 1'b1; in_tag = 8'd5;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_after", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("fl_no_old%0d", i), 64'(out_valid), 64'd0);
        end

        // Reset while FULL
        out_ready = 1'b0;
        push(8'd6, 3'd1, 16'hFFF0);
        push(8'd7, 3'd1, 16'hFFF1);
        rst = 1'b1;
        #1;
        check("rstf_in_ready_during", 64'(in_ready), 64'd0);
        tick();
        check("rstf_outputs", 64'({out_valid, out_err, out_tag, out_imm}), 64'd0);
        check("rstf_in_ready_held", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rstf_in_ready_release", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick();
        check("rstf_nothing_left", 64'(out_valid), 64'd0);

        // Random streaming with 50% backpressure against a scoreboard
        sent = 0; got = 0; cyc = 0; stall = 1'b0; held = '0;
        while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
            @(posedge clk);
            #1;
            in_valid  = (sent < 100) && ($urandom_range(0, 1) == 1);
            in_op     = 3'($urandom_range(0, 7));
            in_imm    = 16'($urandom);
            in_tag    = sent[7:0];
            out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (stall)
                check("stream_stall_hold", 64'({out_valid, out_imm, out_err, out_tag}),
                      64'({1'b1, held}));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stream_spurious", 64'(out_tag), 64'hFFFF_FFFF);
                end else begin
                    exp_beat = q.pop_front();
                    check($sformatf("stream_beat%0d", got), 64'({out_imm, out_err, out_tag}),
                          64'(exp_beat));
                    got++;
                end
            end
            stall = out_valid && !out_ready;
            held  = {out_imm, out_err, out_tag};
            if (in_valid && in_ready) begin
                m = model(in_op, in_imm);
                q.push_back({m[31:0], m[32], in_tag});
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_count", 64'(got), 64'd100);
        if (cyc >= 3000) check("stream_timeout", 64'(cyc), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
